// File: rtl/game_ctrl_if.sv
// Handshake bundle between the game controller and its surroundings:
// tick and button pulses going in, registered game status coming out.
interface game_ctrl_if;
  logic       div_hsec;
  logic       btn_start;
  logic       btn_vol_up;
  logic       btn_vol_dn;
  logic       hit;
  logic       goal;
  logic [2:0] state;
  logic [2:0] curr_hp;
  logic [2:0] volume;

  modport master (
    output div_hsec, btn_start, btn_vol_up, btn_vol_dn, hit, goal,
    input  state, curr_hp, volume
  );

  modport slave (
    input  div_hsec, btn_start, btn_vol_up, btn_vol_dn, hit, goal,
    output state, curr_hp, volume
  );
endinterface

// File: rtl/game_ctrl.sv
// Round sequencer for a simple game: INIT -> WAIT countdown -> GAME -> WIN/LOSE
// countdown -> INIT, with hit-point tracking and a saturating volume control.
module game_ctrl #(
  parameter int MAX_HP      = 7,
  parameter int WAIT_TICKS  = 6,
  parameter int END_TICKS   = 10,
  parameter int VOL_DEFAULT = 3
) (
  input  logic         clk,
  input  logic         rst,
  game_ctrl_if.slave   bus
);

  localparam logic [2:0] ST_INIT = 3'd0;
  localparam logic [2:0] ST_WAIT = 3'd1;
  localparam logic [2:0] ST_GAME = 3'd2;
  localparam logic [2:0] ST_WIN  = 3'd3;
  localparam logic [2:0] ST_LOSE = 3'd4;
  localparam logic [2:0] VOL_MAX = 3'd5;

  logic [2:0] state_q, state_d;
  logic [2:0] hp_q, hp_d;
  logic [2:0] vol_q, vol_d;
  logic [3:0] tick_q, tick_d;
  logic       wait_done, end_done, counting;

  // A countdown finishes on the pulse that would make the count reach the limit.
  assign wait_done = bus.div_hsec && (tick_q == 4'(WAIT_TICKS - 1));
  assign end_done  = bus.div_hsec && (tick_q == 4'(END_TICKS - 1));
  assign counting  = (state_q == ST_WAIT) || (state_q == ST_WIN) || (state_q == ST_LOSE);

  // State register and all output-facing flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_INIT;
      hp_q    <= 3'd0;
      vol_q   <= 3'(VOL_DEFAULT);
      tick_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      hp_q    <= hp_d;
      vol_q   <= vol_d;
      tick_q  <= tick_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_INIT: if (bus.btn_start) state_d = ST_WAIT;
      ST_WAIT: if (wait_done)     state_d = ST_GAME;
      ST_GAME: begin
        if (bus.goal)                     state_d = ST_WIN;
        else if (bus.hit && hp_q <= 3'd1) state_d = ST_LOSE;
      end
      ST_WIN, ST_LOSE: if (end_done) state_d = ST_INIT;
      default: state_d = ST_INIT;
    endcase
  end

  // Hit points and tick counter, evaluated against the pending transition.
  always_comb begin
    hp_d   = hp_q;
    tick_d = tick_q;

    if (state_d != state_q)
      tick_d = 4'd0;
    else if (counting && bus.div_hsec)
      tick_d = tick_q + 4'd1;

    case (state_q)
      ST_INIT: ;
      ST_WAIT: if (wait_done) hp_d = 3'(MAX_HP);
      ST_GAME: begin
        // goal wins over hit; a hit at 1 hp floors at 0 rather than wrapping
        if (!bus.goal && bus.hit)
          hp_d = (hp_q > 3'd1) ? hp_q - 3'd1 : 3'd0;
      end
      ST_WIN, ST_LOSE: if (end_done) hp_d = 3'd0;
      default: hp_d = 3'd0;
    endcase
  end

  // Volume is live in every state; simultaneous up/down cancel out.
  always_comb begin
    vol_d = vol_q;
    if (bus.btn_vol_up && !bus.btn_vol_dn && vol_q < VOL_MAX)
      vol_d = vol_q + 3'd1;
    else if (bus.btn_vol_dn && !bus.btn_vol_up && vol_q > 3'd0)
      vol_d = vol_q - 3'd1;
  end

  assign bus.state   = state_q;
  assign bus.curr_hp = hp_q;
  assign bus.volume  = vol_q;

endmodule

// File: tb/tb_game_ctrl.sv
// Self-checking bench for game_ctrl: directed vector table, hand-written
// multi-cycle sequences, then random pulses against a countdown-style model.
module tb_game_ctrl;
  localparam int MAX_HP = 7, WAIT_TICKS = 6, END_TICKS = 10, VOL_DEFAULT = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  game_ctrl_if bus ();

  game_ctrl #(
    .MAX_HP(MAX_HP), .WAIT_TICKS(WAIT_TICKS),
    .END_TICKS(END_TICKS), .VOL_DEFAULT(VOL_DEFAULT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic s, u, d, h, g, v;
    logic [2:0] st, hp, vol;
  } vec_t;

  vec_t tbl[$];
  int   n_chk = 0;
  int   n_err = 0;

  // reference model: phase plus pulses remaining in the current countdown
  int m_st, m_hp, m_vol, m_left;

  task automatic chk(input string name, input int idx, input logic [2:0] act, input logic [2:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[%0d]: got %0d expected %0d", name, idx, act, exp);
    end
  endtask

  task automatic chk_all(input string name, input int idx, input int st, input int hp, input int vol);
    chk({name, "_state"}, idx, bus.state,   3'(st));
    chk({name, "_hp"},    idx, bus.curr_hp, 3'(hp));
    chk({name, "_vol"},   idx, bus.volume,  3'(vol));
  endtask

  function automatic void add(input logic s, u, d, h, g, v, input int st, hp, vol);
    vec_t r;
    r.s = s; r.u = u; r.d = d; r.h = h; r.g = g; r.v = v;
    r.st = 3'(st); r.hp = 3'(hp); r.vol = 3'(vol);
    tbl.push_back(r);
  endfunction

  // One clock of input pulses; returns 1 ns after the active edge with inputs released.
  task automatic drive(input logic s, u, d, h, g, v);
    @(negedge clk);
    bus.btn_start = s; bus.btn_vol_up = u; bus.btn_vol_dn = d;
    bus.hit = h; bus.goal = g; bus.div_hsec = v;
    @(posedge clk);
    #1;
    bus.btn_start = 0; bus.btn_vol_up = 0; bus.btn_vol_dn = 0;
    bus.hit = 0; bus.goal = 0; bus.div_hsec = 0;
  endtask

  task automatic model_reset();
    m_st = 0; m_hp = 0; m_vol = VOL_DEFAULT; m_left = 0;
  endtask

  task automatic model_step(input logic s, u, d, h, g, v);
    case (m_st)
      0: if (s) begin m_st = 1; m_left = WAIT_TICKS; end
      1: if (v) begin
           m_left--;
           if (m_left == 0) begin m_st = 2; m_hp = MAX_HP; end
         end
      2: if (g) begin m_st = 3; m_left = END_TICKS; end
         else if (h) begin
           if (m_hp > 1) m_hp--;
           else begin m_hp = 0; m_st = 4; m_left = END_TICKS; end
         end
      default: if (v) begin
           m_left--;
           if (m_left == 0) begin m_st = 0; m_hp = 0; end
         end
    endcase
    if (u && !d) m_vol = (m_vol < 5) ? m_vol + 1 : 5;
    if (d && !u) m_vol = (m_vol > 0) ? m_vol - 1 : 0;
  endtask

  initial begin
    bus.btn_start = 0; bus.btn_vol_up = 0; bus.btn_vol_dn = 0;
    bus.hit = 0; bus.goal = 0; bus.div_hsec = 0;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk_all("reset", 0, 0, 0, VOL_DEFAULT);
    @(negedge clk);
    rst = 0;

    // directed table: start, wait countdown, hits down to LOSE, end countdown, volume
    add(1,0,0,0,0,0, 1,0,3);
    for (int i = 0; i < 5; i++) add(0,0,0,0,0,1, 1,0,3);
    add(0,0,0,0,0,1, 2,7,3);
    for (int k = 6; k >= 1; k--) begin
      add(0,0,0,1,0,0, 2,k,3);
      add(0,0,0,0,0,0, 2,k,3);
    end
    add(0,0,0,1,0,0, 4,0,3);
    add(1,0,0,0,0,0, 4,0,3);
    for (int i = 0; i < 9; i++) add(0,0,0,0,0,1, 4,0,3);
    add(0,0,0,0,0,1, 0,0,3);
    add(0,0,0,1,0,0, 0,0,3);
    add(0,1,0,0,0,0, 0,0,4);
    add(0,1,0,0,0,0, 0,0,5);
    add(0,1,0,0,0,0, 0,0,5);
    add(0,1,1,0,0,0, 0,0,5);
    add(0,0,1,0,0,0, 0,0,4);
    add(0,0,1,0,0,0, 0,0,3);
    add(0,0,1,0,0,0, 0,0,2);
    add(0,0,1,0,0,0, 0,0,1);
    add(0,0,1,0,0,0, 0,0,0);
    add(0,0,1,0,0,0, 0,0,0);
    add(0,0,0,0,0,0, 0,0,0);

    foreach (tbl[i]) begin
      drive(tbl[i].s, tbl[i].u, tbl[i].d, tbl[i].h, tbl[i].g, tbl[i].v);
      chk("tbl_state", i, bus.state,   tbl[i].st);
      chk("tbl_hp",    i, bus.curr_hp, tbl[i].hp);
      chk("tbl_vol",   i, bus.volume,  tbl[i].vol);
    end

    // goal and hit together in GAME: goal wins, hp frozen in WIN
    drive(1,0,0,0,0,0);
    repeat (6) drive(0,0,0,0,0,1);
    chk_all("prio_enter", 0, 2, 7, 0);
    repeat (3) drive(0,0,0,1,0,0);
    chk_all("prio_hp4", 0, 2, 4, 0);
    drive(0,0,0,1,1,0);
    chk_all("prio_goalhit", 0, 3, 4, 0);
    drive(0,0,0,1,0,0);
    chk_all("prio_hit_win", 0, 3, 4, 0);
    drive(1,0,0,0,1,0);
    chk_all("prio_start_win", 0, 3, 4, 0);
    repeat (9) drive(0,0,0,0,0,1);
    chk_all("prio_end9", 0, 3, 4, 0);
    drive(0,0,0,0,0,1);
    chk_all("prio_end10", 0, 0, 0, 0);

    // asynchronous reset mid-WAIT with tick count 4
    drive(0,1,0,0,0,0);
    drive(1,0,0,0,0,0);
    repeat (4) drive(0,0,0,0,0,1);
    chk_all("arst_pre", 0, 1, 0, 1);
    #2 rst = 1;
    #1 chk_all("arst_now", 0, 0, 0, VOL_DEFAULT);
    #1 rst = 0;
    drive(1,0,0,0,0,0);
    repeat (5) drive(0,0,0,0,0,1);
    chk_all("arst_wait5", 0, 1, 0, VOL_DEFAULT);
    drive(0,0,0,0,0,1);
    chk_all("arst_wait6", 0, 2, 7, VOL_DEFAULT);

    // start pulses in WAIT must not restart the countdown
    drive(0,0,0,0,1,0);
    repeat (END_TICKS) drive(0,0,0,0,0,1);
    chk_all("ign_init", 0, 0, 0, VOL_DEFAULT);
    drive(1,0,0,0,0,0);
    repeat (3) drive(0,0,0,0,0,1);
    drive(1,0,0,0,0,0);
    chk_all("ign_start_wait", 0, 1, 0, VOL_DEFAULT);
    repeat (2) drive(0,0,0,0,0,1);
    chk_all("ign_wait5", 0, 1, 0, VOL_DEFAULT);
    drive(0,0,0,0,0,1);
    chk_all("ign_wait6", 0, 2, 7, VOL_DEFAULT);

    // random pulses against the model
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    model_reset();
    for (int n = 0; n < 3000; n++) begin
      logic s, u, d, h, g, v;
      s = ($urandom_range(7) == 0);
      u = ($urandom_range(9) == 0);
      d = ($urandom_range(9) == 0);
      h = ($urandom_range(4) == 0);
      g = ($urandom_range(19) == 0);
      v = ($urandom_range(1) == 0);
      drive(s, u, d, h, g, v);
      model_step(s, u, d, h, g, v);
      chk_all("rnd", n, m_st, m_hp, m_vol);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/game_ctrl.md
GAME_CTRL -- requirements
Module: game_ctrl

Interface
REQ-001 Parameter MAX_HP, default 7: hit points loaded on GAME entry, range 1..7.
REQ-002 Parameter WAIT_TICKS, default 6: div_hsec pulses spent in WAIT (3 s), range 1..15.
REQ-003 Parameter END_TICKS, default 10: div_hsec pulses spent in WIN or LOSE before returning to INIT, range 1..15.
REQ-004 Parameter VOL_DEFAULT, default 3: volume after reset, range 0..5.
REQ-005 clk  input  1  single system clock; all state changes on rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 div_hsec  input  1  half-second tick; one-clk-wide pulse synchronous to clk.
REQ-008 btn_start  input  1  debounced start request; one-clk-wide pulse.
REQ-009 btn_vol_up  input  1  volume increment request; one-clk-wide pulse.
REQ-010 btn_vol_dn  input  1  volume decrement request; one-clk-wide pulse.
REQ-011 hit  input  1  player damage event; one-clk-wide pulse.
REQ-012 goal  input  1  win condition reached; one-clk-wide pulse.
REQ-013 state  output  3  INIT=000, WAIT=001, GAME=010, WIN=011, LOSE=100; registered.
REQ-014 curr_hp  output  3  current hit points; registered.
REQ-015 volume  output  3  volume level 0..5; registered.

Function
REQ-016 The block SHALL hold a 4-bit tick counter, cleared on every state transition, that increments on div_hsec in WAIT, WIN and LOSE only.
REQ-017 INIT: btn_start -> WAIT at the next edge; all other event inputs are ignored except the volume inputs.
REQ-018 WAIT: when div_hsec arrives with the tick count equal to WAIT_TICKS-1 -> GAME at that edge, with curr_hp loaded to MAX_HP at the same edge.
REQ-019 GAME: goal -> WIN at the next edge, with curr_hp unchanged.
REQ-020 GAME: hit with curr_hp > 1 -> curr_hp decrements by 1, state stays GAME.
REQ-021 GAME: hit with curr_hp == 1 -> curr_hp = 0 and state = LOSE at the same edge.
REQ-022 GAME: goal and hit in the same cycle -> goal has priority: WIN, curr_hp unchanged.
REQ-023 GAME: curr_hp SHALL never wrap below 0, and hit SHALL be ignored outside GAME.
REQ-024 WIN/LOSE: when div_hsec arrives with the tick count equal to END_TICKS-1 -> INIT at that edge, and curr_hp is cleared to 0 at the same edge.
REQ-025 WIN/LOSE: btn_start and goal SHALL be ignored.
REQ-026 WAIT and WIN/LOSE: btn_start SHALL be ignored and SHALL NOT restart the tick count.
REQ-027 Volume SHALL be adjustable in every state.
REQ-028 btn_vol_up increments volume, saturating at 5.
REQ-029 btn_vol_dn decrements volume, saturating at 0.
REQ-030 btn_vol_up and btn_vol_dn asserted in the same cycle -> volume unchanged.
REQ-031 Undefined state encodings (101..111) SHALL return to INIT at the next edge, with curr_hp = 0 and volume preserved.
REQ-032 All outputs SHALL be driven directly from flops, with no combinational path from any input to any output.

Reset
REQ-033 While rst=1, immediately and independent of clk: state=INIT, curr_hp=0, volume=VOL_DEFAULT, tick counter=0.
REQ-034 Reset asserted mid-GAME or mid-countdown SHALL abandon the round, with no residual hp or tick carried over after release.
REQ-035 First active edge after rst deasserts SHALL evaluate inputs normally.

Verification
REQ-036 Reset, then btn_start, then 6 div_hsec pulses -> state 000->001->010, and curr_hp=7 on the cycle GAME is entered.
REQ-037 In GAME, 7 hit pulses spaced by idle cycles -> curr_hp 6,5,4,3,2,1; the 7th hit gives curr_hp=0 and state=100 at the same edge; then 10 div_hsec pulses -> state=000 and curr_hp=0.
REQ-038 In GAME with curr_hp=4, goal and hit in the same cycle -> state=011, curr_hp=4; a further hit -> no change; after 10 div_hsec pulses -> state=000.
REQ-039 From volume=3: three btn_vol_up -> 4,5,5; then btn_vol_up and btn_vol_dn together -> 5; then six btn_vol_dn -> ends at 0 and stays at 0.
REQ-040 rst pulsed asynchronously (between clk edges) while in WAIT with tick count 4 -> outputs reach 000/0/VOL_DEFAULT before the next edge; a new start requires the full 6 pulses again.
REQ-041 btn_start pulses in WAIT, WIN and LOSE, and hit pulses in INIT -> no state, hp or tick effect.
